// File: rtl/nx_indirect_access_cntrl_mt.sv
// Indirect register-to-memory access controller: a command register drives single,
// auto-increment and swept accesses into N_TABLES memories over one arbitrated port.
module nx_indirect_access_cntrl_mt #(
  parameter int N_REG_ADDR_BITS = 11,
  parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS = 11'h170,
  parameter int N_DATA_BITS  = 96,
  parameter int N_ENTRIES    = 512,
  parameter int N_TABLES     = 4,
  parameter int N_TIMER_BITS = 6,
  parameter int RD_LATENCY   = 1,
  localparam int AW = $clog2(N_ENTRIES),
  localparam int TW = (N_TABLES > 1) ? $clog2(N_TABLES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_stb,
  input  logic [N_REG_ADDR_BITS-1:0] reg_addr,
  input  logic [3:0]                 cmnd_op,
  input  logic [AW-1:0]              cmnd_addr,
  input  logic [TW-1:0]              cmnd_table_id,
  input  logic [N_TABLES*AW-1:0]     addr_limit,
  input  logic [N_DATA_BITS-1:0]     wr_dat,
  output logic [N_DATA_BITS-1:0]     rd_dat,
  output logic [2:0]                 stat_code,
  output logic [AW-1:0]              stat_addr,
  output logic [TW-1:0]              stat_table_id,
  output logic                       enable,
  output logic                       sw_cs,
  output logic                       sw_we,
  output logic [AW-1:0]              sw_add,
  output logic [TW-1:0]              sw_table_id,
  output logic [N_DATA_BITS-1:0]     sw_wdat,
  input  logic [N_DATA_BITS-1:0]     sw_rdat,
  input  logic                       grant,
  output logic                       yield
);

  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [3:0] OP_NOP = 4'd0, OP_READ = 4'd1, OP_WRITE = 4'd2, OP_ENABLE = 4'd3,
                         OP_DISABLE = 4'd4, OP_RESET = 4'd5, OP_INIT = 4'd6,
                         OP_READ_NEXT = 4'd7, OP_SIM_TMO = 4'd14, OP_ACK_ERROR = 4'd15;

  localparam logic [2:0] ST_RDY = 3'd0, ST_BSY = 3'd1, ST_TMO = 3'd2, ST_OVR = 3'd3,
                         ST_NXM = 3'd4, ST_UOP = 3'd5, ST_PDN = 3'd7;

  typedef enum logic [3:0] {
    POWERDOWN, READY, ERROR, DO_WRITE, DO_READ, READ_WAIT, READ_DONE, DO_RESET, DO_INIT
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              stat_code_q, stat_code_d;
  logic                    enable_q, enable_d;
  logic [N_DATA_BITS-1:0]  rd_dat_q, rd_dat_d;
  logic                    sw_cs_q, sw_cs_d, sw_we_q, sw_we_d;
  logic [AW-1:0]           sw_add_q, sw_add_d;
  logic [TW-1:0]           sw_table_id_q, sw_table_id_d;
  logic [N_DATA_BITS-1:0]  sw_wdat_q, sw_wdat_d;
  logic [TW-1:0]           stat_table_id_q, stat_table_id_d;
  logic [N_TIMER_BITS-1:0] timer_q, timer_d;
  logic                    sim_tmo_q, sim_tmo_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           lat_q, lat_d;
  logic [AW-1:0]           end_q, end_d;

  function automatic logic [AW-1:0] limit_of(input logic [TW-1:0] tid);
    logic [AW-1:0] r;
    r = '0;
    for (int t = 0; t < N_TABLES; t++)
      if (int'(tid) == t) r = addr_limit[t*AW +: AW];
    return r;
  endfunction

  logic                    cmd, eff_grant, op_known, op_passive, bad_addr, in_flight;
  logic [AW-1:0]           cmd_limit, chk_addr;
  logic [N_TIMER_BITS-1:0] timer_inc;

  assign cmd        = wr_stb && (reg_addr == CMND_ADDRESS);
  assign eff_grant  = grant && !sim_tmo_q;
  assign cmd_limit  = limit_of(cmnd_table_id);
  assign chk_addr   = (cmnd_op == OP_READ_NEXT) ? rd_ptr_q : cmnd_addr;
  assign op_passive = (cmnd_op == OP_NOP) || (cmnd_op == OP_SIM_TMO);
  assign bad_addr   = !op_passive && ((int'(cmnd_table_id) >= N_TABLES) || (chk_addr > cmd_limit));
  assign timer_inc  = timer_q + 1'b1;
  assign in_flight  = (state_q == DO_WRITE) || (state_q == DO_READ) || (state_q == DO_RESET) ||
                      (state_q == DO_INIT) || (state_q == READ_WAIT) || (state_q == READ_DONE);

  always_comb begin
    op_known = 1'b1;
    if ((cmnd_op > OP_READ_NEXT) && (cmnd_op != OP_SIM_TMO) && (cmnd_op != OP_ACK_ERROR))
      op_known = 1'b0;
  end

  // Next-state logic; every output flop is loaded from the decision made here.
  always_comb begin
    logic   accept, tmo_hit;
    logic [2:0] err;
    state_d         = state_q;
    enable_d        = enable_q;
    rd_dat_d        = rd_dat_q;
    sw_add_d        = sw_add_q;
    sw_table_id_d   = sw_table_id_q;
    sw_wdat_d       = sw_wdat_q;
    stat_table_id_d = stat_table_id_q;
    timer_d         = '0;
    sim_tmo_d       = sim_tmo_q;
    rd_ptr_d        = rd_ptr_q;
    lat_d           = lat_q;
    end_d           = end_q;
    accept          = 1'b0;
    tmo_hit         = 1'b0;
    err             = ST_RDY;

    if (cmd && (cmnd_op == OP_SIM_TMO) && (state_q != POWERDOWN) && (state_q != ERROR))
      sim_tmo_d = 1'b1;

    case (state_q)
      POWERDOWN: begin
        rd_dat_d = wr_dat;
        if (cmd && (cmnd_op == OP_ENABLE)) begin
          state_d  = READY;
          enable_d = 1'b1;
        end
      end
      READY: begin
        if (cmd) begin
          if (!op_known) begin
            state_d = ERROR;
            err     = ST_UOP;
          end else if (bad_addr) begin
            state_d = ERROR;
            err     = ST_NXM;
          end else begin
            case (cmnd_op)
              OP_WRITE: begin
                state_d = DO_WRITE; accept = 1'b1;
                sw_add_d = cmnd_addr; sw_wdat_d = wr_dat;
              end
              OP_READ: begin
                state_d = DO_READ; accept = 1'b1;
                sw_add_d = cmnd_addr;
                rd_ptr_d = (cmnd_addr >= cmd_limit) ? '0 : cmnd_addr + 1'b1;
              end
              OP_READ_NEXT: begin
                state_d = DO_READ; accept = 1'b1;
                sw_add_d = rd_ptr_q;
                rd_ptr_d = (rd_ptr_q >= cmd_limit) ? '0 : rd_ptr_q + 1'b1;
              end
              OP_RESET: begin
                state_d = DO_RESET; accept = 1'b1;
                sw_add_d = '0; end_d = cmd_limit; sw_wdat_d = '0;
              end
              OP_INIT: begin
                state_d = DO_INIT; accept = 1'b1;
                sw_add_d = '0; end_d = cmnd_addr; sw_wdat_d = wr_dat;
              end
              OP_DISABLE: begin
                state_d  = POWERDOWN;
                enable_d = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      ERROR: begin
        if (cmd && (cmnd_op == OP_ACK_ERROR))
          state_d = enable_q ? READY : POWERDOWN;
      end
      READ_WAIT: begin
        if (lat_q == '0) state_d = READ_DONE;
        else             lat_d   = lat_q - 1'b1;
      end
      READ_DONE: begin
        rd_dat_d = sw_rdat;
        state_d  = READY;
      end
      default: begin
        // Grant beats a timeout landing in the same cycle.
        if (eff_grant) begin
          case (state_q)
            DO_WRITE: state_d = READY;
            DO_READ: begin
              state_d = READ_WAIT;
              lat_d   = LW'(RD_LATENCY - 1);
            end
            default: begin
              if (sw_add_q == end_q) state_d  = READY;
              else                   sw_add_d = sw_add_q + 1'b1;
            end
          endcase
        end else if (&timer_inc) begin
          state_d   = ERROR;
          err       = ST_TMO;
          tmo_hit   = 1'b1;
          sim_tmo_d = 1'b0;
        end else begin
          timer_d = timer_inc;
        end
      end
    endcase

    if (in_flight && cmd && !op_passive) begin
      state_d = ERROR;
      err     = !op_known ? ST_UOP : bad_addr ? ST_NXM : tmo_hit ? ST_TMO : ST_OVR;
    end

    if (accept) begin
      stat_table_id_d = cmnd_table_id;
      sw_table_id_d   = cmnd_table_id;
    end

    case (state_d)
      POWERDOWN: stat_code_d = ST_PDN;
      READY:     stat_code_d = ST_RDY;
      ERROR:     stat_code_d = (state_q == ERROR) ? stat_code_q : err;
      default:   stat_code_d = ST_BSY;
    endcase

    sw_we_d = (state_d == DO_WRITE) || (state_d == DO_RESET) || (state_d == DO_INIT);
    sw_cs_d = sw_we_d || (state_d == DO_READ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= POWERDOWN;
      stat_code_q     <= ST_PDN;
      enable_q        <= 1'b0;
      rd_dat_q        <= '0;
      sw_cs_q         <= 1'b0;
      sw_we_q         <= 1'b0;
      sw_add_q        <= '0;
      sw_table_id_q   <= '0;
      sw_wdat_q       <= '0;
      stat_table_id_q <= '0;
      timer_q         <= '0;
      sim_tmo_q       <= 1'b0;
      rd_ptr_q        <= '0;
      lat_q           <= '0;
      end_q           <= '0;
    end else begin
      state_q         <= state_d;
      stat_code_q     <= stat_code_d;
      enable_q        <= enable_d;
      rd_dat_q        <= rd_dat_d;
      sw_cs_q         <= sw_cs_d;
      sw_we_q         <= sw_we_d;
      sw_add_q        <= sw_add_d;
      sw_table_id_q   <= sw_table_id_d;
      sw_wdat_q       <= sw_wdat_d;
      stat_table_id_q <= stat_table_id_d;
      timer_q         <= timer_d;
      sim_tmo_q       <= sim_tmo_d;
      rd_ptr_q        <= rd_ptr_d;
      lat_q           <= lat_d;
      end_q           <= end_d;
    end
  end

  assign rd_dat        = rd_dat_q;
  assign stat_code     = stat_code_q;
  assign stat_addr     = limit_of(stat_table_id_q);
  assign stat_table_id = stat_table_id_q;
  assign enable        = enable_q;
  assign sw_cs         = sw_cs_q;
  assign sw_we         = sw_we_q;
  assign sw_add        = sw_add_q;
  assign sw_table_id   = sw_table_id_q;
  assign sw_wdat       = sw_wdat_q;
  assign yield         = timer_q[N_TIMER_BITS-1];

endmodule
